// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART program loader.
//   loader_state_t : loader FSM states
//   byte_t / word_t: received byte and assembled 32-bit word
//   WORD_BYTES     : bytes per little-endian word
//   fill_lane()    : insert a byte into the lane selected by a 2-bit index
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int WORD_BYTES = 4;

    // Little-endian lane fill: byte k lands in bits [8k+7:8k].
    function automatic word_t fill_lane(input word_t w, input logic [1:0] idx, input byte_t b);
        word_t r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/uart_program_loader_byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs a little-endian byte stream into 32-bit words.
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : re-arm; drops any partial word and a pending word_valid
//   byte_en     : a byte is accepted this cycle
//   byte_in     : accepted byte
//   word_valid  : one-cycle pulse, the cycle after the 4th byte is accepted
//   word        : completed word (held until the next word completes)
// The assembly register and the output word register are separate, so bytes
// of the following word can arrive while the completed word is being used.
// -----------------------------------------------------------------------------
module byte_word_packer
    import uart_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  logic  byte_en,
    input  byte_t byte_in,
    output logic  word_valid,
    output word_t word
);

    logic [1:0] idx_r;
    word_t      asm_r;
    word_t      word_r;
    logic       valid_r;

    // Lane index, partial-word assembly and completed-word hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r   <= 2'd0;
            asm_r   <= 32'd0;
            word_r  <= 32'd0;
            valid_r <= 1'b0;
        end else if (clear) begin
            idx_r   <= 2'd0;
            asm_r   <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (byte_en) begin
                asm_r <= fill_lane(asm_r, idx_r, byte_in);
                idx_r <= idx_r + 2'd1;
                if (idx_r == 2'(WORD_BYTES - 1)) begin
                    word_r  <= fill_lane(asm_r, idx_r, byte_in);
                    valid_r <= 1'b1;
                end
            end
        end
    end

    assign word_valid = valid_r;
    assign word       = word_r;

endmodule

// File: rtl/uart_program_loader.sv
// -----------------------------------------------------------------------------
// uart_program_loader
// Loads a length-prefixed program image from the UART byte stream into
// instruction memory: a 32-bit LE word count N followed by N 32-bit LE words,
// written to consecutive word addresses starting at BASE_ADDR.
//   clk, reset     : clock, asynchronous active-high reset
//   start          : pulse that arms (or aborts and re-arms) a load
//   in_data/in_valid/in_ready : byte stream handshake from the UART
//   mem_addr/mem_wdata/mem_we : instruction memory write port
//   busy           : loading (length or data phase)
//   done / error   : sticky completion / failure (overflow or timeout)
//   words_written  : memory writes completed in the current load
// -----------------------------------------------------------------------------
module uart_program_loader
    import uart_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          BASE_ADDR  = 0,
    parameter int          MAX_WORDS  = 4096,
    parameter logic [31:0] TIMEOUT    = 32'd10000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           words_written
);

    loader_state_t         state_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           words_written_r;
    word_t                 n_r;
    logic [31:0]           tmo_r;
    logic                  done_r;
    logic                  error_r;

    logic                  byte_en_s;
    logic                  word_valid_s;
    word_t                 word_s;
    logic                  tmo_hit_s;
    logic [31:0]           tmo_next_s;

    // start takes priority over a coincident byte: that byte is discarded.
    assign in_ready  = (state_r == LEN) || (state_r == DATA);
    assign byte_en_s = in_valid && in_ready && !start;

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start),
        .byte_en    (byte_en_s),
        .byte_in    (in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Inactivity counter: restarts on every accepted byte.
    always_comb begin
        tmo_next_s = tmo_r + 32'd1;
        tmo_hit_s  = 1'b0;
        if (byte_en_s) begin
            tmo_next_s = 32'd0;
        end else if (tmo_next_s == TIMEOUT) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Loader FSM with address, count, timeout and sticky status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            mem_addr_r      <= ADDR_WIDTH'(BASE_ADDR);
            words_written_r <= 32'd0;
            n_r             <= 32'd0;
            tmo_r           <= 32'd0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
        end else if (start) begin
            state_r         <= LEN;
            mem_addr_r      <= ADDR_WIDTH'(BASE_ADDR);
            words_written_r <= 32'd0;
            tmo_r           <= 32'd0;
            done_r          <= 1'b0;
            error_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                LEN: begin
                    tmo_r <= tmo_next_s;
                    if (word_valid_s) begin
                        n_r <= word_s;
                        if (word_s == 32'd0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else if (word_s > 32'(MAX_WORDS)) begin
                            state_r <= ERR;
                            error_r <= 1'b1;
                        end else begin
                            state_r <= DATA;
                        end
                    end else if (tmo_hit_s) begin
                        state_r <= ERR;
                        error_r <= 1'b1;
                    end
                end
                DATA: begin
                    tmo_r <= tmo_next_s;
                    // The strobe cycle is word_valid_s; account for it now.
                    if (word_valid_s) begin
                        mem_addr_r      <= mem_addr_r + ADDR_WIDTH'(1);
                        words_written_r <= words_written_r + 32'd1;
                    end
                    if (word_valid_s && ((words_written_r + 32'd1) == n_r)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else if (tmo_hit_s) begin
                        state_r <= ERR;
                        error_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                ERR: begin
                    state_r <= ERR;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // The strobe is gated by DATA so the length word never reaches memory.
    assign mem_we        = word_valid_s && (state_r == DATA);
    assign mem_wdata     = word_s;
    assign mem_addr      = mem_addr_r;
    assign busy          = (state_r == LEN) || (state_r == DATA);
    assign done          = done_r;
    assign error         = error_r;
    assign words_written = words_written_r;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] words_written;

    int vectors     = 0;
    int miscompares = 0;
    int stalls      = 0;
    int rdy_drop    = 0;

    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];

    uart_program_loader #(
        .ADDR_WIDTH (12),
        .BASE_ADDR  (0),
        .MAX_WORDS  (4096),
        .TIMEOUT    (32'd100)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Record memory writes and any in_ready drop while loading.
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (busy && !in_ready) rdy_drop++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            step();
            w++;
        end
        stalls += w;
        if (!in_ready) check("byte_accept_timeout", 32'(in_ready), 32'd1);
        step();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(8'((w >> (8 * k)) & 32'hFF));
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        step(); step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we",   32'(mem_we),   32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_error",    32'(error),    32'd0);
        check("rst_addr",     32'(mem_addr), 32'd0);
        check("rst_wdata",    mem_wdata,     32'd0);
        check("rst_ww",       words_written, 32'd0);
        reset = 1'b0;
        step();

        // Two-word image.
        clear_log();
        pulse_start();
        check("t1_busy_after_start", 32'(busy),     32'd1);
        check("t1_ready_in_len",     32'(in_ready), 32'd1);
        send_word(32'd2);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        in_valid = 1'b0;
        step(); step();
        check("t1_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() >= 2) begin
            check("t1_addr0", 32'(wa_q[0]), 32'd0);
            check("t1_data0", wd_q[0],      32'h12345678);
            check("t1_addr1", 32'(wa_q[1]), 32'd1);
            check("t1_data1", wd_q[1],      32'hDEADBEEF);
        end
        check("t1_done", 32'(done),     32'd1);
        check("t1_ww",   words_written, 32'd2);
        check("t1_busy", 32'(busy),     32'd0);

        // Empty image.
        clear_log();
        pulse_start();
        check("t2_done_cleared", 32'(done), 32'd0);
        send_word(32'd0);
        in_valid = 1'b0;
        check("t2_done_not_yet", 32'(done), 32'd0);
        step();
        check("t2_done",     32'(done),         32'd1);
        check("t2_in_ready", 32'(in_ready),     32'd0);
        check("t2_nwrites",  32'(wa_q.size()),  32'd0);
        check("t2_ww",       words_written,     32'd0);

        // Length overflow, then re-arm.
        clear_log();
        pulse_start();
        send_word(32'h00001001);
        in_valid = 1'b0;
        step(); step();
        check("t3_error",    32'(error),        32'd1);
        check("t3_done",     32'(done),         32'd0);
        check("t3_in_ready", 32'(in_ready),     32'd0);
        check("t3_busy",     32'(busy),         32'd0);
        check("t3_nwrites",  32'(wa_q.size()),  32'd0);
        pulse_start();
        check("t3_rearm_error", 32'(error), 32'd0);
        check("t3_rearm_busy",  32'(busy),  32'd1);

        // Inactivity timeout in the middle of a word.
        clear_log();
        pulse_start();
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        in_valid = 1'b0;
        repeat (50) step();
        check("t4_no_error_yet", 32'(error), 32'd0);
        check("t4_still_busy",   32'(busy),  32'd1);
        repeat (60) step();
        check("t4_error",   32'(error),       32'd1);
        check("t4_busy",    32'(busy),        32'd0);
        check("t4_nwrites", 32'(wa_q.size()), 32'd0);
        check("t4_ww",      words_written,    32'd0);

        // Three words, in_valid held continuously.
        clear_log();
        stalls   = 0;
        rdy_drop = 0;
        pulse_start();
        send_word(32'd3);
        send_word(32'h11223344);
        send_word(32'h55667788);
        send_word(32'h99AABBCC);
        in_valid = 1'b0;
        step(); step();
        check("t5_nwrites", 32'(wa_q.size()), 32'd3);
        if (wa_q.size() >= 3) begin
            check("t5_addr0", 32'(wa_q[0]), 32'd0);
            check("t5_data0", wd_q[0],      32'h11223344);
            check("t5_addr1", 32'(wa_q[1]), 32'd1);
            check("t5_data1", wd_q[1],      32'h55667788);
            check("t5_addr2", 32'(wa_q[2]), 32'd2);
            check("t5_data2", wd_q[2],      32'h99AABBCC);
        end
        check("t5_stalls",   32'(stalls),   32'd0);
        check("t5_rdy_drop", 32'(rdy_drop), 32'd0);
        check("t5_done",     32'(done),     32'd1);
        check("t5_ww",       words_written, 32'd3);
        check("t5_addr_end", 32'(mem_addr), 32'd3);

        // Reset on the cycle the write strobe would assert.
        clear_log();
        pulse_start();
        send_word(32'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        in_data  = 8'h04;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check("t6_mem_we",   32'(mem_we),       32'd0);
        check("t6_nwrites",  32'(wa_q.size()),  32'd0);
        check("t6_in_ready", 32'(in_ready),     32'd0);
        check("t6_busy",     32'(busy),         32'd0);
        check("t6_done",     32'(done),         32'd0);
        check("t6_error",    32'(error),        32'd0);
        check("t6_addr",     32'(mem_addr),     32'd0);
        check("t6_wdata",    mem_wdata,         32'd0);
        check("t6_ww",       words_written,     32'd0);
        reset = 1'b0;
        step();
        pulse_start();
        send_word(32'd1);
        send_word(32'hCAFEF00D);
        in_valid = 1'b0;
        step(); step();
        check("t6_reload_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() >= 1) begin
            check("t6_reload_addr", 32'(wa_q[0]), 32'd0);
            check("t6_reload_data", wd_q[0],      32'hCAFEF00D);
        end
        check("t6_reload_done", 32'(done),     32'd1);
        check("t6_reload_ww",   words_written, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
